seg_pipe_adder: RTL and testbench

- Parametrised, pipelined successor to the fixed 6-bit combinational adder in the Vedic multiplier datapath.
- Adds or subtracts two WIDTH-bit operands, one SEG-bit segment per pipeline stage, with the carry registered between stages.
- Accepts one operation per cycle under a valid/ready handshake with backpressure.
- Intended for the final partial-product summation of wide (16/32-bit) Vedic multipliers, where a single-cycle ripple adder limits Fmax.

---
 rtl/seg_pipe_adder.sv | 153 +++++++++++++++
 tb/tb_seg_pipe_adder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: pipelined WIDTH-bit adder/subtractor, one SEG-bit segment per stage.
//
// The carry ripples through registers instead of through one long combinational chain.
// Each stage adds one segment. It then registers four things: the partial sum, the carry
// out of that segment, the operands (which later stages still need) and the op flags.
// A single enable (adv) moves all stages together. The pipeline therefore holds completely
// under backpressure, and bubbles stay where they are while the output is stalled.
//
// Optional feature: define SEG_PIPE_ADDER_SAT_EN to saturate sum at the output.
// For an add, a carry out forces sum to all-ones. For a subtract, a borrow forces sum to
// zero. cout always reports the raw carry.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   in_valid  in   a/b/cin/sub valid this cycle
//   in_ready  out  operation accepted this cycle when in_valid is also high
//   a, b      in   WIDTH-bit unsigned operands
//   cin       in   carry-in (ignored when sub=1)
//   sub       in   0: a+b+cin, 1: a-b (a + ~b + 1)
//   out_valid out  sum/cout hold a result
//   out_ready in   consumer takes the result this cycle
//   sum       out  WIDTH-bit result modulo 2^WIDTH
//   cout      out  carry out; for sub, 0 means borrow (a < b)
//
// WIDTH must be an integer multiple of SEG; SEG == WIDTH yields a single registered stage.

module seg_pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned STAGES = WIDTH / SEG;

    // Stage registers: index k holds the output of stage k (1..STAGES).
    logic [STAGES:1][WIDTH-1:0] r_a;
    logic [STAGES:1][WIDTH-1:0] r_b;
    logic [STAGES:1][WIDTH-1:0] r_sum;
    logic [STAGES:1]            r_carry;
    logic [STAGES:1]            r_sub;
    logic [STAGES:1]            r_valid;

    // Stage inputs: index k feeds stage k+1 (index 0 is the block input).
    logic [STAGES-1:0][WIDTH-1:0] w_a;
    logic [STAGES-1:0][WIDTH-1:0] w_b;
    logic [STAGES-1:0][WIDTH-1:0] w_sum;
    logic [STAGES-1:0]            w_carry;
    logic [STAGES-1:0]            w_sub;
    logic [STAGES-1:0]            w_valid;

    // Per-stage segment adder result and the partial sum to register.
    logic [STAGES-1:0][SEG:0]     w_seg;
    logic [STAGES-1:0][WIDTH-1:0] w_sum_nxt;

    logic w_adv;

    assign w_adv    = !r_valid[STAGES] || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        w_a     = '0;
        w_b     = '0;
        w_sum   = '0;
        w_carry = '0;
        w_sub   = '0;
        w_valid = '0;

        // b is inverted once at entry, so every stage performs a plain add.
        w_a[0]     = a;
        w_b[0]     = sub ? ~b : b;
        w_carry[0] = sub | cin;
        w_sub[0]   = sub;
        w_valid[0] = in_valid;

        for (int s = 1; s < int'(STAGES); s++) begin
            w_a[s]     = r_a[s];
            w_b[s]     = r_b[s];
            w_sum[s]   = r_sum[s];
            w_carry[s] = r_carry[s];
            w_sub[s]   = r_sub[s];
            w_valid[s] = r_valid[s];
        end
    end

    always_comb begin
        w_seg     = '0;
        w_sum_nxt = '0;
        for (int s = 0; s < int'(STAGES); s++) begin
            w_seg[s] = {1'b0, w_a[s][s*SEG +: SEG]}
                     + {1'b0, w_b[s][s*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_carry[s]};
            w_sum_nxt[s]                = w_sum[s];
            w_sum_nxt[s][s*SEG +: SEG]  = w_seg[s][SEG-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= '0;
            r_sub   <= '0;
            r_valid <= '0;
        end else if (w_adv) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                r_a[s+1]     <= w_a[s];
                r_b[s+1]     <= w_b[s];
                r_sum[s+1]   <= w_sum_nxt[s];
                r_carry[s+1] <= w_seg[s][SEG];
                r_sub[s+1]   <= w_sub[s];
                r_valid[s+1] <= w_valid[s];
            end
        end
    end

    assign out_valid = r_valid[STAGES];
    assign cout      = r_carry[STAGES];

`ifdef SEG_PIPE_ADDER_SAT_EN
    always_comb begin
        sum = r_sum[STAGES];
        if (!r_sub[STAGES] && r_carry[STAGES]) begin
            sum = '1;
        end else if (r_sub[STAGES] && !r_carry[STAGES]) begin
            sum = '0;
        end
    end

    // Already-consumed operand segments and the last stage's operand copies have no loads.
    logic w_unused_bits;
    assign w_unused_bits = ^{w_a, w_b, r_a[STAGES], r_b[STAGES]};
`else
    assign sum = r_sum[STAGES];

    logic w_unused_bits;
    assign w_unused_bits = ^{w_a, w_b, r_a[STAGES], r_b[STAGES], r_sub[STAGES]};
`endif

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed testbench for seg_pipe_adder with WIDTH=16 and SEG=4, giving a latency of 4.
module tb_seg_pipe_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;

    int checks = 0;
    int errors = 0;

    seg_pipe_adder #(
        .WIDTH(16),
        .SEG  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one op from an idle pipeline and returns the first valid output and its latency.
    task automatic send_one(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                            input logic tsub, output logic [15:0] osum, output logic ocout,
                            output int lat);
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        osum  = sum;
        ocout = cout;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (sum !== 16'h0000) begin
            errors++; $display("FAIL reset_sum: got %h want 0000", sum);
        end
        checks++;
        if (cout !== 1'b0) begin
            errors++; $display("FAIL reset_cout: got %b want 0", cout);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add;
        logic [15:0] s; logic c; int lat;
        send_one(16'h1234, 16'h4321, 1'b0, 1'b0, s, c, lat);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL add_latency: got %0d want 4", lat);
        end
        checks++;
        if (s !== 16'h5555 || c !== 1'b0) begin
            errors++; $display("FAIL add_basic: got %h/%b want 5555/0", s, c);
        end
        send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, lat);
        checks++;
        if (s !== 16'h0000 || c !== 1'b1 || lat !== 4) begin
            errors++; $display("FAIL add_ripple: got %h/%b lat %0d want 0000/1 lat 4", s, c, lat);
        end
        send_one(16'h00FF, 16'h0000, 1'b1, 1'b0, s, c, lat);
        checks++;
        if (s !== 16'h0100 || c !== 1'b0) begin
            errors++; $display("FAIL add_cin: got %h/%b want 0100/0", s, c);
        end
    endtask

    task automatic test_sub;
        logic [15:0] s; logic c; int lat;
        send_one(16'h0005, 16'h0007, 1'b0, 1'b1, s, c, lat);
        checks++;
        if (s !== 16'hFFFE || c !== 1'b0 || lat !== 4) begin
            errors++; $display("FAIL sub_borrow: got %h/%b lat %0d want FFFE/0 lat 4", s, c, lat);
        end
        // cin must be ignored for subtraction.
        send_one(16'h0007, 16'h0005, 1'b1, 1'b1, s, c, lat);
        checks++;
        if (s !== 16'h0002 || c !== 1'b1) begin
            errors++; $display("FAIL sub_no_borrow: got %h/%b want 0002/1", s, c);
        end
    endtask

    task automatic test_saturation;
        logic [15:0] s; logic c; int lat;
        logic [15:0] exp_add; logic [15:0] exp_sub;
`ifdef SEG_PIPE_ADDER_SAT_EN
        exp_add = 16'hFFFF;
        exp_sub = 16'h0000;
`else
        exp_add = 16'h0010;
        exp_sub = 16'hFFFA;
`endif
        send_one(16'hFFF0, 16'h0020, 1'b0, 1'b0, s, c, lat);
        checks++;
        if (s !== exp_add || c !== 1'b1) begin
            errors++; $display("FAIL sat_add: got %h/%b want %h/1", s, c, exp_add);
        end
        send_one(16'h0003, 16'h0009, 1'b0, 1'b1, s, c, lat);
        checks++;
        if (s !== exp_sub || c !== 1'b0) begin
            errors++; $display("FAIL sat_sub: got %h/%b want %h/0", s, c, exp_sub);
        end
    endtask

    task automatic test_back_to_back;
        int next_i = 1;
        int got    = 0;
        int cyc    = 0;
        logic acc; logic drn; logic stalled;
        @(posedge clk);
        #1;
        while ((got < 8 || next_i <= 8) && cyc < 60) begin
            stalled   = (cyc >= 5 && cyc <= 7);
            out_ready = !stalled;
            if (next_i <= 8) begin
                in_valid = 1'b1;
                a        = 16'(next_i);
                b        = 16'(next_i * 256);
                cin      = 1'b0;
                sub      = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (stalled) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++; $display("FAIL stall_in_ready cyc %0d: got %b want 0", cyc, in_ready);
                end
            end
            if (drn) begin
                got++;
                checks++;
                if (got > 8 || sum !== 16'(got * 257) || cout !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result #%0d: got %h/%b want %h/0", got, sum, cout,
                             16'(got * 257));
                end
            end
            @(posedge clk);
            #1;
            if (acc) next_i++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got !== 8) begin
            errors++; $display("FAIL b2b_count: got %0d results want 8", got);
        end
        repeat (6) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL b2b_extra: got out_valid %b sum %h want 0", out_valid, sum);
            end
        end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            a        = 16'(i * 16'h1111);
            b        = 16'h0001;
            cin      = 1'b0;
            sub      = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: got v%b s%h c%b r%b want v0 s0000 c0 r1",
                     out_valid, sum, cout, in_ready);
        end
        repeat (8) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_ghost: got out_valid %b sum %h want 0", out_valid, sum);
            end
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_saturation;
        test_back_to_back;
        test_reset_midflight;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
